// File: rtl/palette_loader.sv
`default_nettype none
`timescale 1ns/1ps
// palette_loader: fetches an R,G,B byte palette over an Avalon-MM read master
// into a register array, using the start/processing handshake of the update handler.
module palette_loader #(
   parameter int PARAM_IDX   = 2,
   parameter int NUM_COLOURS = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              mem_address,
   output logic                     mem_read,
   input  logic                     mem_waitrequest,
   input  logic [7:0]               mem_readdata,
   input  logic [7:0][31:0]         hps_params,
   input  logic                     start,
   output logic                     processing,
   output logic                     palette_valid,
   output logic [255:0][2:0][7:0]   local_palette
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_COLOURS - 1);

   state_t                   state_q, state_d;
   logic [31:0]              base_q, base_d;
   logic [9:0]               cnt_q, cnt_d;
   logic [7:0]               idx_q, idx_d;
   logic [1:0]               chan_q, chan_d;
   logic                     valid_q, valid_d;
   logic [255:0][2:0][7:0]   palette_q;
   logic                     xfer;
   logic                     unused_params;

   // Only one parameter word matters; the rest are folded away on purpose.
   assign unused_params = ^hps_params;

   assign xfer = (state_q == S_READ) && !mem_waitrequest;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = hps_params[PARAM_IDX];
               cnt_d   = '0;
               idx_d   = '0;
               chan_d  = '0;
               valid_d = 1'b0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (xfer) begin
               cnt_d = cnt_q + 10'd1;
               if (chan_q == 2'd2) begin
                  chan_d = 2'd0;
                  idx_d  = idx_q + 8'd1;
               end else begin
                  chan_d = chan_q + 2'd1;
               end
               if ((idx_q == LAST_IDX) && (chan_q == 2'd2)) begin
                  state_d = S_DONE;
                  valid_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         palette_q <= '0;
      end else if (xfer) begin
         palette_q[idx_q][chan_q] <= mem_readdata;
      end
   end

   assign mem_read      = (state_q == S_READ);
   assign processing    = (state_q == S_READ);
   assign mem_address   = mem_read ? (base_q + {22'd0, cnt_q}) : 32'd0;
   assign palette_valid = valid_q;
   assign local_palette = palette_q;

endmodule
`default_nettype wire

// File: tb/tb_palette_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for palette_loader: scoreboarded address stream, table-driven palette checks.
module tb_palette_loader;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic st = 1'b0;
   logic sel = 1'b0;
   logic wreq = 1'b0;
   logic [7:0][31:0] params = '0;

   logic [31:0] a0, a4;
   logic r0, r4, p0, p4, v0, v4;
   logic [255:0][2:0][7:0] pal0, pal4;
   logic [7:0] d0, d4;
   logic s0, s4;

   assign d0 = a0[7:0];
   assign d4 = a4[7:0];
   assign s0 = st & ~sel;
   assign s4 = st & sel;

   always #5 clk = ~clk;

   palette_loader dut (
      .clk(clk), .reset(reset), .mem_address(a0), .mem_read(r0),
      .mem_waitrequest(wreq), .mem_readdata(d0), .hps_params(params),
      .start(s0), .processing(p0), .palette_valid(v0), .local_palette(pal0)
   );

   palette_loader #(.PARAM_IDX(2), .NUM_COLOURS(4)) dut4 (
      .clk(clk), .reset(reset), .mem_address(a4), .mem_read(r4),
      .mem_waitrequest(wreq), .mem_readdata(d4), .hps_params(params),
      .start(s4), .processing(p4), .palette_valid(v4), .local_palette(pal4)
   );

   logic [31:0] ma;
   logic mr, mp, mv;
   assign ma = sel ? a4 : a0;
   assign mr = sel ? r4 : r0;
   assign mp = sel ? p4 : p0;
   assign mv = sel ? v4 : v0;

   int total = 0;
   int bad = 0;
   logic [31:0] expq[$];

   typedef struct {
      bit         inst;
      int         idx;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pe_t;
   pe_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_palette(input bit inst);
      logic [23:0] act;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].inst == inst) begin
            if (inst) act = {pal4[tbl[i].idx][0], pal4[tbl[i].idx][1], pal4[tbl[i].idx][2]};
            else      act = {pal0[tbl[i].idx][0], pal0[tbl[i].idx][1], pal0[tbl[i].idx][2]};
            chk($sformatf("palette[%0d]", tbl[i].idx), 64'(act),
                64'({tbl[i].r, tbl[i].g, tbl[i].b}));
         end
      end
   endtask

   // Drives start, models the expected address stream, optionally stops early.
   task automatic run_load(input logic [31:0] base, input int n, input bit stall,
                           input int abort_after);
      int cyc = 0;
      int proc = 0;
      int stalls = 0;
      int acc = 0;
      bit seen = 0;
      bit first = 1;
      bit prevstall = 0;
      logic [31:0] prev = '0;
      expq.delete();
      for (int k = 0; k < 3 * n; k++) expq.push_back(base + 32'(k));
      @(negedge clk);
      params[2] = base;
      st = 1'b1;
      while (cyc < 6 * n + 50) begin
         @(negedge clk);
         cyc++;
         wreq = stall && ((cyc % 10) == 9);
         if (mp) begin
            seen = 1;
            proc++;
            if (first) begin
               chk("valid_low_in_load", 64'(mv), 64'd0);
               first = 0;
            end
            if (prevstall) chk("addr_hold", 64'(ma), 64'(prev));
            if (wreq) begin
               stalls++;
            end else begin
               if (expq.size() == 0) chk("extra_read", 64'd1, 64'd0);
               else chk("addr", 64'(ma), 64'(expq.pop_front()));
               acc++;
               if (abort_after > 0 && acc == abort_after) return;
            end
            prevstall = wreq;
            prev = ma;
         end else if (seen) begin
            break;
         end
      end
      wreq = 1'b0;
      chk("load_finished", 64'(seen && !mp), 64'd1);
      chk("reads_left", 64'(expq.size()), 64'd0);
      chk("proc_cycles", 64'(proc), 64'(3 * n + stalls));
      chk("valid_after", 64'(mv), 64'd1);
      chk("read_idle", 64'(mr), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int busy;
      tbl[0] = '{0, 0,   8'h00, 8'h01, 8'h02};
      tbl[1] = '{0, 1,   8'h03, 8'h04, 8'h05};
      tbl[2] = '{0, 85,  8'hFF, 8'h00, 8'h01};
      tbl[3] = '{0, 255, 8'hFD, 8'hFE, 8'hFF};
      tbl[4] = '{1, 0,   8'hFE, 8'hFF, 8'h00};
      tbl[5] = '{1, 1,   8'h01, 8'h02, 8'h03};
      tbl[6] = '{1, 3,   8'h07, 8'h08, 8'h09};
      tbl[7] = '{1, 4,   8'h00, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      chk("rst_read", 64'(r0), 64'd0);
      chk("rst_proc", 64'(p0), 64'd0);
      chk("rst_valid", 64'(v0), 64'd0);
      chk("rst_addr", 64'(a0), 64'd0);
      chk("rst_palette_zero", 64'(pal0 == '0), 64'd1);
      reset = 1'b0;

      // Basic load.
      run_load(32'hC000_0000, 256, 0, 0);
      check_palette(0);

      // Start held high after DONE must not retrigger.
      busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (p0 || r0) busy++;
      end
      chk("held_start_no_reload", 64'(busy), 64'd0);
      chk("held_start_valid", 64'(v0), 64'd1);

      // Re-arm after a single low cycle.
      @(negedge clk);
      st = 1'b0;
      run_load(32'h0000_1000, 256, 0, 0);
      check_palette(0);

      // Stalled load.
      @(negedge clk);
      st = 1'b0;
      @(negedge clk);
      run_load(32'hC000_0000, 256, 1, 0);
      check_palette(0);

      // Reset in the middle of a load.
      @(negedge clk);
      st = 1'b0;
      @(negedge clk);
      run_load(32'hC000_0010, 256, 0, 101);
      #2 reset = 1'b1;
      #1;
      chk("midrst_read", 64'(r0), 64'd0);
      chk("midrst_proc", 64'(p0), 64'd0);
      chk("midrst_valid", 64'(v0), 64'd0);
      chk("midrst_pal00", 64'(pal0[0][0]), 64'd0);
      st = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("postrst_idle", 64'(p0), 64'd0);
      run_load(32'hC000_0000, 256, 0, 0);
      check_palette(0);

      // Small palette with address wrap.
      @(negedge clk);
      st = 1'b0;
      sel = 1'b1;
      @(negedge clk);
      run_load(32'hFFFF_FFFE, 4, 0, 0);
      check_palette(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Upstream neighbour of the frame update handler. On `start`, fetches a 256-colour RGB palette (768 bytes, R,G,B per entry) from HPS-visible memory over an Avalon-MM read master.
- Fills the `local_palette` register array that the update handler reads combinationally for index→RGB565 conversion.
- Uses the same `start`/`processing` handshake as the update handler, so the HPS control FSM can sequence "load palette, then update frame".

Parameters:
- PARAM_IDX, 2, index into `hps_params` of the word holding the palette base byte address.
- NUM_COLOURS, 256, palette entries loaded; legal range 1..256.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_address  out  32  Avalon byte address
- mem_read  out  1  Avalon read request
- mem_waitrequest  in  1  Avalon stall; the transfer completes on a rising edge where mem_read=1 and mem_waitrequest=0
- mem_readdata  in  8  read data, valid in the completing cycle (zero-latency slave)
- hps_params  in  [7:0] x 32  HPS parameter words
- start  in  1  level request to load
- processing  out  1  high while a load is in progress
- palette_valid  out  1  high once a complete load has finished; cleared when a new load starts
- local_palette  out  [255:0][2:0] x 8  palette; [i][0]=R, [i][1]=G, [i][2]=B, raw 8-bit values as stored in memory

Behaviour:
- Reset (async, any time including mid-load):
  - state=IDLE; mem_read=0; mem_address=0; processing=0; palette_valid=0.
  - All `local_palette` bytes = 0.
  - Byte counter, colour index and channel counters = 0.
- States: IDLE, READ, DONE.
- IDLE:
  - mem_read=0, processing=0.
  - On an edge with start=1: latch base=hps_params[PARAM_IDX]; clear idx, chan, cnt; clear palette_valid; go to READ.
- READ:
  - processing=1; mem_read=1; mem_address=base+cnt (32-bit wrap, no error).
  - The address is held stable while mem_waitrequest=1; no counter or array change during a stall.
  - On each completing edge: local_palette[idx][chan] <= mem_readdata; cnt += 1.
  - Channel/index update: if chan==2 then chan<=0 and idx+=1, else chan+=1. No divider is used.
  - The completing edge where idx==NUM_COLOURS-1 and chan==2 goes to DONE.
- Timing and throughput:
  - With no stalls, one byte is accepted per cycle.
  - A full load takes 3*NUM_COLOURS cycles in READ (768 by default).
  - Each waitrequest cycle adds one cycle.
- DONE:
  - mem_read=0, processing=0, palette_valid=1.
  - Stays in DONE while start=1; returns to IDLE on the first edge with start=0.
  - This requires start to deassert before a reload; holding start high never retriggers.
- Other conditions:
  - start changing during READ is ignored, and base does not change mid-load.
  - hps_params changing mid-load has no effect.
- Output timing:
  - mem_read, mem_address and processing are decoded from registered state/counters, with no combinational path from inputs.
  - Entries not yet written during a load keep their previous values. The update handler must only use the palette when palette_valid=1 / processing=0.

Test Plan:
- Basic load: hps_params[2]=32'hC000_0000, start=1, slave returns low byte of mem_address, no stalls.
  - First read at 32'hC000_0000.
  - processing high for exactly 768 cycles.
  - local_palette[0]={00,01,02}, [1]={03,04,05}, [255]={FD,FE,FF}.
  - palette_valid=1 afterwards.
- Stalls: mem_waitrequest high 1 cycle in every 10 (the update handler's bench pattern).
  - mem_address held during each stall.
  - Same palette contents as the basic load.
  - Total READ cycles = 768 + number of stall cycles.
- Held start: start stays 1 after DONE.
  - No second load; processing stays 0.
- Re-arm: drop start for 1 cycle, then raise it with base 32'h0000_1000.
  - New load begins at 32'h0000_1000; palette_valid goes 0 during the load, then 1.
- Reset mid-load: assert reset asynchronously after 100 accepted bytes.
  - Immediately: mem_read=0, processing=0, palette_valid=0, local_palette[0][0]=0.
  - After release: IDLE; the next start restarts at cnt=0.
- NUM_COLOURS=4, base 32'hFFFF_FFFE:
  - 12 reads; address wraps to 32'h0000_0000 at the third byte.
  - DONE after the [3][2] write.
